// File: rtl/autorange_sequencer.sv
// Autorange sequencer: drives conversion starts, steps the input range from results,
// averages accepted counts (only when AUTORANGE_AVG_EN is defined) and hands off results.
module autorange_sequencer #(
  parameter int RANGE_SEL_WIDTH = 2,
  parameter int NUM_RANGES      = 4,
  parameter int COUNT_W         = 32,
  parameter int UP_THRESH       = 180000,
  parameter int DN_THRESH       = 16000,
  parameter int AVG_LOG2        = 2,
  parameter int SETTLE_TICKS    = 64,
  parameter int MAX_HOPS        = 3,
  parameter int WDOG_TICKS      = 400000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  output logic                       meas_start_o,
  input  logic                       meas_busy_i,
  input  logic                       meas_ready_i,
  input  logic                       meas_error_i,
  input  logic [COUNT_W-1:0]         meas_count_i,
  output logic [RANGE_SEL_WIDTH-1:0] range_sel_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [COUNT_W-1:0]         out_count_o,
  output logic [RANGE_SEL_WIDTH-1:0] out_range_o,
  output logic                       out_over_o,
  output logic                       fault_o
);

`ifdef AUTORANGE_AVG_EN
  localparam int AVG_N = AVG_LOG2;
`else
  // single sample per result; AVG_LOG2 has no effect in this build
  localparam int AVG_N = AVG_LOG2 * 0;
`endif
  localparam int SMP_W = AVG_N + 1;
  localparam int SET_W = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
  localparam int WD_W  = (WDOG_TICKS > 1) ? $clog2(WDOG_TICKS) : 1;
  localparam int HOP_W = $clog2(MAX_HOPS + 1);

  localparam logic [SMP_W-1:0]           SMP_LAST = SMP_W'((1 << AVG_N) - 1);
  localparam logic [SET_W-1:0]           SET_LAST = SET_W'(SETTLE_TICKS - 1);
  localparam logic [WD_W-1:0]            WD_LAST  = WD_W'(WDOG_TICKS - 1);
  localparam logic [HOP_W-1:0]           HOP_MAX  = HOP_W'(MAX_HOPS);
  localparam logic [RANGE_SEL_WIDTH-1:0] RNG_TOP  = RANGE_SEL_WIDTH'(NUM_RANGES - 1);
  localparam logic [COUNT_W-1:0]         UP_T     = COUNT_W'(UP_THRESH);
  localparam logic [COUNT_W-1:0]         DN_T     = COUNT_W'(DN_THRESH);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_START, S_WAIT, S_EVAL, S_PRESENT, S_FAULT
  } state_e;

  state_e                     state_q, state_d;
  logic [RANGE_SEL_WIDTH-1:0] range_q, range_d;
  logic [HOP_W-1:0]           hops_q, hops_d;
  logic [SMP_W-1:0]           smp_q, smp_d;
  logic [SET_W-1:0]           settle_q, settle_d;
  logic [WD_W-1:0]            wdog_q, wdog_d;
  logic                       ev_err_q, ev_err_d;
  logic [COUNT_W-1:0]         ev_count_q, ev_count_d;
  logic                       meas_start_q, meas_start_d;
  logic                       out_valid_q, out_valid_d;
  logic [COUNT_W-1:0]         out_count_q, out_count_d;
  logic [RANGE_SEL_WIDTH-1:0] out_range_q, out_range_d;
  logic                       out_over_q, out_over_d;
  logic                       fault_q, fault_d;
  logic                       hot, up_ok, dn_ok;
`ifdef AUTORANGE_AVG_EN
  localparam int ACC_W = COUNT_W + AVG_N;
  logic [ACC_W-1:0]           acc_q, acc_d, acc_sum;
`endif

  always_comb begin
    state_d     = state_q;
    range_d     = range_q;
    hops_d      = hops_q;
    smp_d       = smp_q;
    settle_d    = settle_q;
    wdog_d      = wdog_q;
    ev_err_d    = ev_err_q;
    ev_count_d  = ev_count_q;
    out_count_d = out_count_q;
    out_range_d = out_range_q;
    out_over_d  = out_over_q;
`ifdef AUTORANGE_AVG_EN
    acc_d       = acc_q;
    acc_sum     = acc_q + ACC_W'(ev_count_q);
`endif
    hot   = ev_err_q || (ev_count_q > UP_T);
    up_ok = (range_q < RNG_TOP) && (hops_q < HOP_MAX);
    dn_ok = (range_q != '0) && (hops_q < HOP_MAX);

    // enable drop aborts everything except a pending result or a latched fault
    if (!enable_i && state_q != S_FAULT && state_q != S_PRESENT) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            hops_d   = '0;
            smp_d    = '0;
            settle_d = '0;
`ifdef AUTORANGE_AVG_EN
            acc_d    = '0;
`endif
            state_d  = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_q == SET_LAST) state_d = S_START;
          else settle_d = settle_q + SET_W'(1);
        end
        S_START: begin
          if (meas_busy_i) begin
            wdog_d  = '0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (meas_error_i || meas_ready_i) begin
            ev_err_d   = meas_error_i;
            ev_count_d = meas_count_i;
            state_d    = S_EVAL;
          end else if (wdog_q == WD_LAST) begin
            state_d = S_FAULT;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
        S_EVAL: begin
          if (hot && up_ok) begin
            range_d  = range_q + RANGE_SEL_WIDTH'(1);
            hops_d   = hops_q + HOP_W'(1);
            smp_d    = '0;
            settle_d = '0;
`ifdef AUTORANGE_AVG_EN
            acc_d    = '0;
`endif
            state_d  = S_SETTLE;
          end else if (hot) begin
            out_count_d = ev_err_q ? '1 : ev_count_q;
            out_over_d  = 1'b1;
            out_range_d = range_q;
            state_d     = S_PRESENT;
          end else if (ev_count_q < DN_T && dn_ok) begin
            range_d  = range_q - RANGE_SEL_WIDTH'(1);
            hops_d   = hops_q + HOP_W'(1);
            smp_d    = '0;
            settle_d = '0;
`ifdef AUTORANGE_AVG_EN
            acc_d    = '0;
`endif
            state_d  = S_SETTLE;
          end else begin
            smp_d = smp_q + SMP_W'(1);
`ifdef AUTORANGE_AVG_EN
            acc_d = acc_sum;
`endif
            if (smp_q == SMP_LAST) begin
`ifdef AUTORANGE_AVG_EN
              out_count_d = acc_sum[AVG_N +: COUNT_W];
`else
              out_count_d = ev_count_q;
`endif
              out_over_d  = 1'b0;
              out_range_d = range_q;
              state_d     = S_PRESENT;
            end else begin
              state_d = S_START;
            end
          end
        end
        S_PRESENT: begin
          if (out_ready_i) begin
            hops_d  = '0;
            smp_d   = '0;
`ifdef AUTORANGE_AVG_EN
            acc_d   = '0;
`endif
            state_d = enable_i ? S_START : S_IDLE;
          end
        end
        S_FAULT: begin
          if (!enable_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    meas_start_d = (state_d == S_START);
    out_valid_d  = (state_d == S_PRESENT);
    fault_d      = (state_d == S_FAULT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      range_q      <= RNG_TOP;
      hops_q       <= '0;
      smp_q        <= '0;
      settle_q     <= '0;
      wdog_q       <= '0;
      ev_err_q     <= 1'b0;
      ev_count_q   <= '0;
      meas_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_count_q  <= '0;
      out_range_q  <= '0;
      out_over_q   <= 1'b0;
      fault_q      <= 1'b0;
`ifdef AUTORANGE_AVG_EN
      acc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      range_q      <= range_d;
      hops_q       <= hops_d;
      smp_q        <= smp_d;
      settle_q     <= settle_d;
      wdog_q       <= wdog_d;
      ev_err_q     <= ev_err_d;
      ev_count_q   <= ev_count_d;
      meas_start_q <= meas_start_d;
      out_valid_q  <= out_valid_d;
      out_count_q  <= out_count_d;
      out_range_q  <= out_range_d;
      out_over_q   <= out_over_d;
      fault_q      <= fault_d;
`ifdef AUTORANGE_AVG_EN
      acc_q        <= acc_d;
`endif
    end
  end

  assign meas_start_o = meas_start_q;
  assign range_sel_o  = range_q;
  assign out_valid_o  = out_valid_q;
  assign out_count_o  = out_count_q;
  assign out_range_o  = out_range_q;
  assign out_over_o   = out_over_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_autorange_sequencer.sv
// Self-checking bench for autorange_sequencer: directed table, random results against a
// conversion-level reference model, plus hold/reset/watchdog sequences.
module tb_autorange_sequencer;
  localparam int WDOG   = 300;
  localparam int SETTLE = 64;
`ifdef AUTORANGE_AVG_EN
  localparam int NAVG = 4;
`else
  localparam int NAVG = 1;
`endif

  logic        clk = 1'b0, rst_i = 1'b1, enable_i = 1'b0;
  logic        meas_start_o, meas_busy_i = 1'b0, meas_ready_i = 1'b0, meas_error_i = 1'b0;
  logic [31:0] meas_count_i = '0;
  logic [1:0]  range_sel_o, out_range_o;
  logic        out_valid_o, out_ready_i = 1'b0, out_over_o, fault_o;
  logic [31:0] out_count_o;

  autorange_sequencer #(.WDOG_TICKS(WDOG), .SETTLE_TICKS(SETTLE)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
    .meas_start_o(meas_start_o), .meas_busy_i(meas_busy_i), .meas_ready_i(meas_ready_i),
    .meas_error_i(meas_error_i), .meas_count_i(meas_count_i), .range_sel_o(range_sel_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_count_o(out_count_o),
    .out_range_o(out_range_o), .out_over_o(out_over_o), .fault_o(fault_o)
  );

  initial forever #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic err; logic [31:0] cnt; } conv_t;
  typedef struct packed {
    logic [3:0]      npre;
    conv_t [7:0]     pre;
    conv_t           steady;
    logic [31:0]     exp_count;
    logic [1:0]      exp_range;
    logic            exp_over;
  } vec_t;

  int checks = 0, failures = 0;
  conv_t stim[$];
  conv_t steady;
  int    exp_rng[$];
  bit    exp_set[$];
  int    mr = 3;
  logic [31:0] m_count;
  logic [1:0]  m_range;
  logic        m_over;
  int    m_nconv;
  int    last_rdy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic conv_t cv(input logic e, input logic [31:0] c);
    conv_t x;
    x.err = e;
    x.cnt = c;
    return x;
  endfunction

  function automatic vec_t mk(input int n, input conv_t a, input conv_t b, input conv_t c,
                              input conv_t s, input logic [31:0] ec, input logic [1:0] er,
                              input logic eo);
    vec_t v;
    v = '0;
    v.npre = 4'(n);
    v.pre[0] = a;
    v.pre[1] = b;
    v.pre[2] = c;
    v.steady = s;
    v.exp_count = ec;
    v.exp_range = er;
    v.exp_over = eo;
    return v;
  endfunction

  // Reference: walk the conversion list applying the ranging rules; records the range
  // each conversion is taken on and whether a range change preceded it.
  function automatic void model();
    int r, h, n, k;
    longint sum;
    bit chg, up;
    conv_t c;
    r = mr; h = 0; n = 0; k = 0; sum = 0; chg = 0;
    exp_rng.delete();
    exp_set.delete();
    m_count = '0; m_over = 1'b0; m_range = '0;
    while (k < 40) begin
      c = (k < stim.size()) ? stim[k] : steady;
      k++;
      exp_rng.push_back(r);
      exp_set.push_back(chg);
      chg = 0;
      up = c.err || (c.cnt > 32'd180000);
      if (up && r < 3 && h < 3) begin
        r++; h++; sum = 0; n = 0; chg = 1;
      end else if (up) begin
        m_count = c.err ? 32'hFFFF_FFFF : c.cnt;
        m_over = 1'b1; m_range = 2'(r);
        break;
      end else if (c.cnt < 32'd16000 && r > 0 && h < 3) begin
        r--; h++; sum = 0; n = 0; chg = 1;
      end else begin
        sum += longint'(c.cnt);
        n++;
        if (n == NAVG) begin
          m_count = 32'(sum / NAVG);
          m_over = 1'b0; m_range = 2'(r);
          break;
        end
      end
    end
    m_nconv = k;
    mr = r;
  endfunction

  task automatic serve(input conv_t c);
    meas_busy_i = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    meas_busy_i  = 1'b0;
    meas_ready_i = !c.err;
    meas_error_i = c.err;
    meas_count_i = c.cnt;
    last_rdy = cyc;
    @(negedge clk);
    meas_ready_i = 1'b0;
    meas_error_i = 1'b0;
    meas_count_i = $urandom;
  endtask

  task automatic run_result(input logic [31:0] ec, input logic [1:0] er, input logic eo,
                            input bit accept);
    int idx, w;
    bit done;
    conv_t c;
    idx = 0; done = 0;
    while (!done) begin
      w = 0;
      while (!meas_start_o && !out_valid_o && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (w >= 400) begin
        checks++; failures++;
        $display("FAIL wait_timeout actual=no_start_or_valid required=event_within_400 (cycle %0d)", cyc);
        return;
      end
      if (out_valid_o) begin
        done = 1;
      end else begin
        if (idx < exp_rng.size()) begin
          chk("conv_range", range_sel_o, exp_rng[idx]);
          // range flips 2 cycles after the ready pulse; start must be at least SETTLE later
          if (exp_set[idx]) chk("settle_gap_ok", (cyc - last_rdy) >= SETTLE + 2, 1);
        end else begin
          checks++; failures++;
          $display("FAIL extra_conv actual=%0d required=%0d conversions", idx + 1, m_nconv);
        end
        c = (idx < stim.size()) ? stim[idx] : steady;
        serve(c);
        idx++;
      end
    end
    chk("out_count", out_count_o, ec);
    chk("out_range", out_range_o, er);
    chk("out_over", out_over_o, eo);
    chk("conv_used", idx, m_nconv);
    if (accept) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
    end
  endtask

  function automatic conv_t rnd_conv();
    int p;
    p = $urandom_range(0, 99);
    if (p < 10) return cv(1'b1, $urandom);
    if (p < 35) return cv(1'b0, $urandom_range(0, 15999));
    if (p < 60) return cv(1'b0, $urandom_range(180001, 32'hFFFF_FFFF));
    return cv(1'b0, $urandom_range(16000, 180000));
  endfunction

  vec_t vecs[$];
  conv_t E, N;
  logic [31:0] h_count;
  logic [1:0]  h_range;
  logic        h_over;
  bit          bad;
  int          w;

  initial begin
    E = cv(1'b1, 32'd0);
    N = cv(1'b0, 32'd0);
    vecs.push_back(mk(0, N, N, N, cv(0, 50000), 50000, 3, 0));
    vecs.push_back(mk(1, cv(0, 10000), N, N, cv(0, 120000), 120000, 2, 0));
    vecs.push_back(mk(2, cv(0, 10000), cv(0, 10000), N, cv(0, 50000), 50000, 0, 0));
    vecs.push_back(mk(3, E, E, E, E, 32'hFFFF_FFFF, 3, 1));
    vecs.push_back(mk(3, cv(0, 10000), cv(0, 190000), cv(0, 10000), cv(0, 190000), 190000, 2, 1));
    vecs.push_back(mk(1, cv(0, 190000), N, N, cv(0, 100000), 100000, 3, 0));
    vecs.push_back(mk(0, N, N, N, cv(0, 180000), 180000, 3, 0));
    vecs.push_back(mk(0, N, N, N, cv(0, 16000), 16000, 3, 0));
    vecs.push_back(mk(1, cv(0, 15999), N, N, cv(0, 180001), 180001, 3, 1));
    vecs.push_back(mk(3, cv(0, 10000), cv(0, 190000), cv(0, 10000), cv(0, 10000), 10000, 2, 0));

    repeat (3) @(negedge clk);
    chk("rst_range_sel", range_sel_o, 3);
    chk("rst_start", meas_start_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_count", out_count_o, 0);
    chk("rst_out_range", out_range_o, 0);
    chk("rst_over", out_over_o, 0);
    chk("rst_fault", fault_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    enable_i = 1'b1;
    last_rdy = cyc;

    for (int i = 0; i < vecs.size(); i++) begin
      stim.delete();
      for (int j = 0; j < int'(vecs[i].npre); j++) stim.push_back(vecs[i].pre[j]);
      steady = vecs[i].steady;
      model();
      run_result(vecs[i].exp_count, vecs[i].exp_range, vecs[i].exp_over, 1'b1);
    end

    for (int i = 0; i < 25; i++) begin
      stim.delete();
      for (int j = 0; j < 8; j++) stim.push_back(rnd_conv());
      steady = cv(1'b0, $urandom_range(16000, 180000));
      model();
      run_result(m_count, m_range, m_over, 1'b1);
    end

    // result held with no consumer
    stim.delete();
    steady = cv(1'b0, 50000);
    model();
    run_result(m_count, m_range, m_over, 1'b0);
    h_count = out_count_o; h_range = out_range_o; h_over = out_over_o;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!out_valid_o || meas_start_o || out_count_o !== h_count ||
          out_range_o !== h_range || out_over_o !== h_over) bad = 1;
    end
    chk("hold_stable", bad, 0);
    out_ready_i = 1'b1;
    @(negedge clk);
    out_ready_i = 1'b0;
    chk("accept_start_next", meas_start_o, 1);
    chk("accept_valid_drop", out_valid_o, 0);

    // reset with a result pending
    steady = cv(1'b0, 70000);
    model();
    run_result(m_count, m_range, m_over, 1'b0);
    rst_i = 1'b1;
    #1;
    chk("arst_valid", out_valid_o, 0);
    chk("arst_count", out_count_o, 0);
    chk("arst_out_range", out_range_o, 0);
    chk("arst_over", out_over_o, 0);
    chk("arst_range_sel", range_sel_o, 3);
    chk("arst_start", meas_start_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    mr = 3;

    // watchdog: busy with no ready/error
    w = 0;
    while (!meas_start_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("wd_start_seen", meas_start_o, 1);
    meas_busy_i = 1'b1;
    w = 0;
    while (!fault_o && w < WDOG + 50) begin
      @(negedge clk);
      w++;
    end
    chk("wd_latency", w, WDOG + 1);
    chk("wd_fault", fault_o, 1);
    chk("wd_no_start", meas_start_o, 0);
    repeat (5) @(negedge clk);
    chk("wd_fault_latched", fault_o, 1);
    meas_busy_i = 1'b0;
    enable_i = 1'b0;
    @(negedge clk);
    chk("wd_fault_clear", fault_o, 0);
    chk("wd_idle_start", meas_start_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
